gyro_bias_cal: RTL and testbench
================================

// Module: gyro_bias_cal
// PURPOSE
//  Zero-rate bias calibrator between the gyro SPI reader FSM and the tilt integrator.
//  - After reset or RECAL: averages 2^CAL_SHIFT stationary samples per axis.
//  - Then subtracts that bias from every sample, applies a deadband and saturates.
//  - Delivers dx/dy/dz rates with a one-cycle valid strobe, so integrated tilt no longer drifts.
// PARAMETERS
//  CAL_SHIFT  4   log2 of calibration sample count (16 samples)
//  DEADBAND   3   |corrected rate| <= DEADBAND is forced to 0 (raw LSB units)
// PORTS
//  CLK        in   1    system clock, single clock domain
//  RST        in   1    synchronous, active-high reset
//  RAW_X      in   16   signed raw angular rate, X axis
//  RAW_Y      in   16   signed raw angular rate, Y axis
//  RAW_Z      in   16   signed raw angular rate, Z axis
//  RAW_VALID  in   1    one-cycle strobe: RAW_X/Y/Z valid this cycle
//  RECAL      in   1    one-cycle request to discard bias and recalibrate
//  DX         out  16   signed bias-corrected rate, X (to tilt integrator)
//  DY         out  16   signed bias-corrected rate, Y
//  DZ         out  16   signed bias-corrected rate, Z
//  OUT_VALID  out  1    one-cycle strobe: DX/DY/DZ updated
//  CAL_DONE   out  1    high while bias is valid (state RUN)
// BEHAVIOUR
//  Reset
//  - All outputs 0; accumulators, bias registers and sample counter cleared.
//  - State <= CAL.
//  - RST asserted in any cycle (including mid-calibration) overrides all other inputs.
//  State CAL
//  - Each RAW_VALID: add sign-extended RAW_* to a (16+CAL_SHIFT)-bit signed accumulator per axis; count++.
//  - Accepting sample number 2^CAL_SHIFT (count == 2^CAL_SHIFT-1): at that clock edge,
//    bias_* <= (acc_* + RAW_*) >>> CAL_SHIFT (arithmetic shift, floor), state <= RUN, CAL_DONE <= 1.
//  - Samples are consumed, never forwarded: OUT_VALID stays 0; DX/DY/DZ hold.
//  State RUN
//  - RAW_VALID in cycle n: DX/DY/DZ and OUT_VALID=1 visible in cycle n+1.
//    OUT_VALID is 0 in every cycle not directly following an accepted RAW_VALID.
//  - diff = RAW - bias, computed at 17 bits signed, then saturated to [-32768, 32767].
//  - If |diff| <= DEADBAND, output 0; otherwise output the saturated diff.
//  - DX/DY/DZ hold their last value between strobes.
//  RECAL
//  - Honoured in any state: state <= CAL; accumulators, count and CAL_DONE cleared next edge.
//  - Bias registers and DX/DY/DZ hold until the new calibration completes.
//  - RECAL and RAW_VALID in the same cycle: RECAL wins, that sample is dropped
//    (no OUT_VALID, not accumulated).
//  - RECAL asserted during CAL restarts the count from 0.
//  Back-to-back RAW_VALID
//  - RAW_VALID on consecutive cycles is fully supported; one output per input, no stalls.
//  Widths
//  - Accumulator cannot overflow: 2^CAL_SHIFT samples of 16 bits fit in 16+CAL_SHIFT bits.
// TESTING
//  T1 Calibration
//   - Stimulus: reset, then 16 samples of X=+20, Y=-8, Z=0, spaced 3 cycles apart.
//   - Required: CAL_DONE rises the cycle after sample 16; no OUT_VALID throughout.
//  T2 Correction and deadband (after T1)
//   - Stimulus: raw (25, -8, 2).
//   - Required: next cycle OUT_VALID=1, DX=5, DY=0, DZ=0.
//   - Stimulus: raw (23, -12, -4).
//   - Required: DX=0, DY=-4, DZ=-4.
//  T3 Saturation
//   - Stimulus: calibrate X with 16 samples of -100, then raw X=32767.
//   - Required: DX=32767.
//   - Stimulus: calibrate X with +100, then raw X=-32768.
//   - Required: DX=-32768.
//  T4 Floor rounding
//   - Stimulus: X cal samples fifteen 0s and one -17 (sum -17); then raw X=-2.
//   - Required: bias=-2; DX=0.
//  T5 RECAL collision
//   - Stimulus: in RUN, RECAL and RAW_VALID in same cycle.
//   - Required: no OUT_VALID; CAL_DONE=0 next cycle; exactly 16 further samples needed
//     before CAL_DONE=1 again.
//  T6 Reset mid-operation
//   - Stimulus: RST after 9 calibration samples; then 16 samples of X=+7.
//   - Required: all outputs 0 after RST; bias X=7 (earlier samples discarded).
//   - Stimulus: back-to-back valids raw X=7, 17.
//   - Required: DX=0 then DX=10 on consecutive cycles.

Source files
------------

// File: rtl/gyro_bias_cal.sv
// rtl/gyro_bias_cal.sv - zero-rate gyro bias calibrator with deadband and saturation
// Averages 2^CAL_SHIFT stationary samples per axis, then subtracts that bias from live samples.
module gyro_bias_cal #(
   parameter int CAL_SHIFT = 4,
   parameter int DEADBAND  = 3
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic signed [15:0] RAW_X,
   input  logic signed [15:0] RAW_Y,
   input  logic signed [15:0] RAW_Z,
   input  logic               RAW_VALID,
   input  logic               RECAL,
   output logic signed [15:0] DX,
   output logic signed [15:0] DY,
   output logic signed [15:0] DZ,
   output logic               OUT_VALID,
   output logic               CAL_DONE
);

   localparam int ACC_W = 16 + CAL_SHIFT;
   localparam logic signed [16:0] SAT_HI = 17'sd32767;
   localparam logic signed [16:0] SAT_LO = -17'sd32768;
   localparam logic signed [16:0] DB     = 17'(DEADBAND);

   typedef enum logic {S_CAL, S_RUN} state_t;

   state_t                   state, state_nxt;
   logic [CAL_SHIFT-1:0]     count;
   logic signed [ACC_W-1:0]  acc_x, acc_y, acc_z;
   logic signed [ACC_W-1:0]  sum_x, sum_y, sum_z;
   logic signed [15:0]       bias_x, bias_y, bias_z;
   logic signed [15:0]       dx_r, dy_r, dz_r;
   logic                     out_valid_r;
   logic                     last_sample;

   function automatic logic signed [15:0] correct(input logic signed [15:0] raw,
                                                  input logic signed [15:0] bias);
      logic signed [16:0] diff;
      logic signed [15:0] res;
      diff = {raw[15], raw} - {bias[15], bias};
      if (diff > SAT_HI)
         res = 16'sh7fff;
      else if (diff < SAT_LO)
         res = 16'sh8000;
      else
         res = diff[15:0];
      if (diff >= -DB && diff <= DB)
         res = '0;
      return res;
   endfunction

   assign last_sample = (count == {CAL_SHIFT{1'b1}});

   // Sum includes the current sample so the final one lands in the bias on the same edge.
   assign sum_x = acc_x + {{CAL_SHIFT{RAW_X[15]}}, RAW_X};
   assign sum_y = acc_y + {{CAL_SHIFT{RAW_Y[15]}}, RAW_Y};
   assign sum_z = acc_z + {{CAL_SHIFT{RAW_Z[15]}}, RAW_Z};

   always_ff @(posedge CLK) begin
      if (RST)
         state <= S_CAL;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (RECAL)
         state_nxt = S_CAL;
      else if (state == S_CAL && RAW_VALID && last_sample)
         state_nxt = S_RUN;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         count       <= '0;
         acc_x       <= '0;
         acc_y       <= '0;
         acc_z       <= '0;
         bias_x      <= '0;
         bias_y      <= '0;
         bias_z      <= '0;
         dx_r        <= '0;
         dy_r        <= '0;
         dz_r        <= '0;
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= 1'b0;
         // RECAL drops any coincident sample; bias and outputs hold until recalibrated.
         if (RECAL) begin
            count <= '0;
            acc_x <= '0;
            acc_y <= '0;
            acc_z <= '0;
         end else if (RAW_VALID) begin
            if (state == S_CAL) begin
               if (last_sample) begin
                  bias_x <= 16'(sum_x >>> CAL_SHIFT);
                  bias_y <= 16'(sum_y >>> CAL_SHIFT);
                  bias_z <= 16'(sum_z >>> CAL_SHIFT);
                  acc_x  <= '0;
                  acc_y  <= '0;
                  acc_z  <= '0;
                  count  <= '0;
               end else begin
                  acc_x <= sum_x;
                  acc_y <= sum_y;
                  acc_z <= sum_z;
                  count <= count + 1'b1;
               end
            end else begin
               dx_r        <= correct(RAW_X, bias_x);
               dy_r        <= correct(RAW_Y, bias_y);
               dz_r        <= correct(RAW_Z, bias_z);
               out_valid_r <= 1'b1;
            end
         end
      end
   end

   assign DX        = dx_r;
   assign DY        = dy_r;
   assign DZ        = dz_r;
   assign OUT_VALID = out_valid_r;
   assign CAL_DONE  = (state == S_RUN);

endmodule

// File: tb/tb_gyro_bias_cal.sv
// tb/tb_gyro_bias_cal.sv - directed scoreboard bench for gyro_bias_cal
module tb_gyro_bias_cal;

   logic               CLK;
   logic               RST;
   logic signed [15:0] RAW_X, RAW_Y, RAW_Z;
   logic               RAW_VALID;
   logic               RECAL;
   logic signed [15:0] DX, DY, DZ;
   logic               OUT_VALID;
   logic               CAL_DONE;

   typedef struct {
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic signed [15:0] z;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   n_pass  = 0;
   int   n_total = 0;

   gyro_bias_cal #(.CAL_SHIFT(4), .DEADBAND(3)) dut (
      .CLK(CLK), .RST(RST),
      .RAW_X(RAW_X), .RAW_Y(RAW_Y), .RAW_Z(RAW_Z),
      .RAW_VALID(RAW_VALID), .RECAL(RECAL),
      .DX(DX), .DY(DY), .DZ(DZ),
      .OUT_VALID(OUT_VALID), .CAL_DONE(CAL_DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Every OUT_VALID must match the oldest expected result.
   always @(negedge CLK) begin
      if (OUT_VALID === 1'b1) begin
         chk("out_valid_expected", int'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk("dx", int'(DX), int'(cur.x));
            chk("dy", int'(DY), int'(cur.y));
            chk("dz", int'(DZ), int'(cur.z));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic send(input int x, input int y, input int z);
      RAW_X = 16'(x);
      RAW_Y = 16'(y);
      RAW_Z = 16'(z);
      RAW_VALID = 1'b1;
      @(posedge CLK);
      #1;
      RAW_VALID = 1'b0;
   endtask

   task automatic push(input int x, input int y, input int z);
      exp_t e;
      e.x = 16'(x);
      e.y = 16'(y);
      e.z = 16'(z);
      sb.push_back(e);
   endtask

   task automatic recal_pulse();
      RECAL = 1'b1;
      @(posedge CLK);
      #1;
      RECAL = 1'b0;
   endtask

   task automatic cal(input int x, input int y, input int z, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         send(x, y, z);
         if (gap > 0) idle(gap);
      end
   endtask

   initial begin
      RST = 1'b1; RECAL = 1'b0; RAW_VALID = 1'b0;
      RAW_X = '0; RAW_Y = '0; RAW_Z = '0;
      idle(2);
      chk("rst_dx", int'(DX), 0);
      chk("rst_out_valid", int'(OUT_VALID), 0);
      chk("rst_cal_done", int'(CAL_DONE), 0);
      RST = 1'b0;
      idle(1);

      // T1: 16 samples, 3 cycles apart
      cal(20, -8, 0, 15, 2);
      chk("t1_cal_done_before_16", int'(CAL_DONE), 0);
      send(20, -8, 0);
      chk("t1_cal_done_after_16", int'(CAL_DONE), 1);
      idle(2);

      // T2: correction and deadband
      push(5, 0, 0);
      send(25, -8, 2);
      idle(1);
      push(0, -4, -4);
      send(23, -12, -4);
      idle(2);

      // T3: saturation both ways
      recal_pulse();
      cal(-100, 0, 0, 16, 0);
      push(32767, 0, 0);
      send(32767, 0, 0);
      idle(1);
      recal_pulse();
      cal(100, 0, 0, 16, 0);
      push(-32768, 0, 0);
      send(-32768, 0, 0);
      idle(2);

      // T4: floor rounding of negative mean; outputs held through recalibration
      recal_pulse();
      cal(0, 0, 0, 15, 0);
      send(-17, 0, 0);
      chk("t4_cal_done", int'(CAL_DONE), 1);
      chk("t4_dx_held", int'(DX), -32768);
      push(0, 0, 0);
      send(-2, 0, 0);
      idle(2);

      // T5: RECAL collides with RAW_VALID
      RAW_X = 16'sd100; RAW_Y = '0; RAW_Z = '0;
      RAW_VALID = 1'b1; RECAL = 1'b1;
      @(posedge CLK);
      #1;
      RAW_VALID = 1'b0; RECAL = 1'b0;
      chk("t5_no_out_valid", int'(OUT_VALID), 0);
      chk("t5_cal_done_low", int'(CAL_DONE), 0);
      cal(50, -30, 1, 15, 1);
      chk("t5_cal_done_after_15", int'(CAL_DONE), 0);
      send(50, -30, 1);
      chk("t5_cal_done_after_16", int'(CAL_DONE), 1);
      push(10, 0, 0);
      send(60, -30, 1);
      idle(2);

      // T6: reset mid-calibration
      recal_pulse();
      cal(1000, 0, 0, 9, 1);
      RST = 1'b1;
      idle(1);
      RST = 1'b0;
      chk("t6_rst_dx", int'(DX), 0);
      chk("t6_rst_dy", int'(DY), 0);
      chk("t6_rst_dz", int'(DZ), 0);
      chk("t6_rst_out_valid", int'(OUT_VALID), 0);
      chk("t6_rst_cal_done", int'(CAL_DONE), 0);
      cal(7, 0, 0, 15, 0);
      chk("t6_cal_done_after_15", int'(CAL_DONE), 0);
      send(7, 0, 0);
      chk("t6_cal_done_after_16", int'(CAL_DONE), 1);
      push(0, 0, 0);
      push(10, 0, 0);
      RAW_X = 16'sd7; RAW_Y = '0; RAW_Z = '0;
      RAW_VALID = 1'b1;
      @(posedge CLK);
      #1;
      RAW_X = 16'sd17;
      @(posedge CLK);
      #1;
      RAW_VALID = 1'b0;
      chk("t6_b2b_second_valid", int'(OUT_VALID), 1);
      idle(3);
      chk("t6_out_valid_drops", int'(OUT_VALID), 0);

      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
